mem_port_arbiter: RTL and testbench

Round-robin arbiter and access sequencer that shares one single-port memory subsystem (the cache-fronted RAM datapath) between two requesters. Each requester issues read or write transactions over a valid/ready handshake. The arbiter grants one transaction at a time, drives the shared memory port for exactly one access cycle, waits out the memory read latency and returns a one-cycle response pulse to the owning requester. It sits between the CPU/DMA-side masters and the memory top level.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter for two requesters sharing one
// single-port memory. One transaction is in flight at a time. The memory
// port is driven for a single access cycle, the read latency is waited
// out, and a one-cycle response pulse goes back to the owning requester.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_dataIn,
    input  logic                  req0_writeEnable,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_dataIn,
    input  logic                  req1_writeEnable,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_dataOut,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_dataOut,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    output logic                  mem_writeEnable,
    input  logic [DATA_WIDTH-1:0] mem_dataOut,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // Counter must be able to hold READ_LATENCY itself.
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  mem_we_q, mem_we_d;
    logic                  busy_q, busy_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic                  sel_s;
    logic                  accept_s;
    logic                  done_s;
    logic [DATA_WIDTH-1:0] done_data_s;

    // Pick a requester: a lone valid one wins, a tie goes to the one not granted last.
    always_comb begin
        sel_s = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_s = ~last_grant_q;
        end else if (req1_valid) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    assign accept_s   = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept_s && !sel_s;
    assign req1_ready = accept_s && sel_s;

    // Sequencer next state: latch on acceptance, one access cycle, then the read wait.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = we_q;
        mem_we_d     = 1'b0;
        done_s       = 1'b0;
        done_data_s  = {DATA_WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_ACCESS;
                    last_grant_d = sel_s;
                    owner_d      = sel_s;
                    addr_d       = sel_s ? req1_addr : req0_addr;
                    data_d       = sel_s ? req1_dataIn : req0_dataIn;
                    we_d         = sel_s ? req1_writeEnable : req0_writeEnable;
                    mem_we_d     = sel_s ? req1_writeEnable : req0_writeEnable;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY)) begin
                    state_d     = ST_IDLE;
                    done_s      = 1'b1;
                    done_data_s = mem_dataOut;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Route the completion pulse and its data (zero for writes) to the owner only.
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;
        if (done_s && owner_q) begin
            rsp_valid_d = 2'b10;
            rsp1_data_d = done_data_s;
        end else if (done_s) begin
            rsp_valid_d = 2'b01;
            rsp0_data_d = done_data_s;
        end else begin
            rsp_valid_d = 2'b00;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            data_q       <= {DATA_WIDTH{1'b0}};
            we_q         <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp0_data_q  <= {DATA_WIDTH{1'b0}};
            rsp1_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign rsp0_valid      = rsp_valid_q[0];
    assign rsp1_valid      = rsp_valid_q[1];
    assign rsp0_dataOut    = rsp0_data_q;
    assign rsp1_dataOut    = rsp1_data_q;
    assign mem_addr        = addr_q;
    assign mem_dataIn      = data_q;
    assign mem_writeEnable = mem_we_q;
    assign busy            = busy_q;
    assign grant_id        = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle table for the write-then-read
// sequence, directed corner sequences, and randomized traffic checked
// against a transaction-level reference model. A second instance with
// READ_LATENCY=3 covers the long-latency read.
module tb_mem_port_arbiter;

    localparam int RL = 1;

    logic        clk;
    logic        reset;
    logic        v0, r0, we0, v1, r1, we1;
    logic [31:0] a0, a1;
    logic [7:0]  d0, d1;
    logic        rv0, rv1, mwe, busy, gid;
    logic [7:0]  rd0, rd1, mdin, mdout;
    logic [31:0] maddr;

    logic        t3_v0, t3_r0, t3_we0, t3_v1, t3_r1, t3_we1;
    logic [31:0] t3_a0, t3_a1;
    logic [7:0]  t3_d0, t3_d1;
    logic        t3_rv0, t3_rv1, t3_mwe, t3_busy, t3_gid;
    logic [7:0]  t3_rd0, t3_rd1, t3_mdin, t3_mdout;
    logic [31:0] t3_maddr;

    mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0), .req0_addr(a0), .req0_dataIn(d0), .req0_writeEnable(we0),
        .req1_valid(v1), .req1_ready(r1), .req1_addr(a1), .req1_dataIn(d1), .req1_writeEnable(we1),
        .rsp0_valid(rv0), .rsp0_dataOut(rd0), .rsp1_valid(rv1), .rsp1_dataOut(rd1),
        .mem_addr(maddr), .mem_dataIn(mdin), .mem_writeEnable(mwe), .mem_dataOut(mdout),
        .busy(busy), .grant_id(gid)
    );

    mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(t3_v0), .req0_ready(t3_r0), .req0_addr(t3_a0), .req0_dataIn(t3_d0), .req0_writeEnable(t3_we0),
        .req1_valid(t3_v1), .req1_ready(t3_r1), .req1_addr(t3_a1), .req1_dataIn(t3_d1), .req1_writeEnable(t3_we1),
        .rsp0_valid(t3_rv0), .rsp0_dataOut(t3_rd0), .rsp1_valid(t3_rv1), .rsp1_dataOut(t3_rd1),
        .mem_addr(t3_maddr), .mem_dataIn(t3_mdin), .mem_writeEnable(t3_mwe), .mem_dataOut(t3_mdout),
        .busy(t3_busy), .grant_id(t3_gid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory environment for the RL=1 instance: data appears exactly one cycle
    // after a read access and is 0xEE at any other time.
    bit [255:0] env_wr;
    logic [7:0] env_mem [256];
    bit         env_busy_q;
    bit         env_v_q;
    logic [7:0] env_rd_q;
    always @(posedge clk) begin
        env_busy_q <= busy;
        env_v_q    <= busy && !env_busy_q && !mwe;
        env_rd_q   <= env_wr[maddr[7:0]] ? env_mem[maddr[7:0]] : (maddr[7:0] ^ 8'h5A);
        if (mwe) begin
            env_mem[maddr[7:0]] <= mdin;
            env_wr[maddr[7:0]]  <= 1'b1;
        end
    end
    assign mdout = env_v_q ? env_rd_q : 8'hEE;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Transaction-level reference model.
    logic [7:0]  sh [256];
    bit          m_idle, m_rsp, m_last, m_owner, m_we, m_hs0, m_hs1;
    int          m_elapsed, m_dur;
    logic [31:0] m_maddr;
    logic [7:0]  m_mdata, m_rdata;
    logic [7:0]  m_hold [2];
    bit          act_r0, act_r1;
    int          gq [$];

    task automatic model_reset();
        m_idle = 1'b1; m_rsp = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
        m_elapsed = 0; m_dur = 0; m_maddr = 32'h0; m_mdata = 8'h0; m_rdata = 8'h0;
        m_hold[0] = 8'h0; m_hold[1] = 8'h0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit e_r0, e_r1;
        @(negedge clk);
        e_r0 = m_idle && v0 && (!v1 || m_last);
        e_r1 = m_idle && v1 && !e_r0;
        m_hs0 = e_r0; m_hs1 = e_r1;
        act_r0 = r0; act_r1 = r1;
        if (r0) gq.push_back(0);
        if (r1) gq.push_back(1);
        chk("ready0", 32'(r0), 32'(e_r0));
        chk("ready1", 32'(r1), 32'(e_r1));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("mem_we", 32'(mwe), 32'(!m_idle && m_elapsed == 1 && m_we));
        chk("mem_addr", maddr, m_maddr);
        chk("mem_dataIn", 32'(mdin), 32'(m_mdata));
        chk("grant_id", 32'(gid), 32'(m_owner));
        chk("rsp0_valid", 32'(rv0), 32'(m_rsp && !m_owner));
        chk("rsp1_valid", 32'(rv1), 32'(m_rsp && m_owner));
        chk("rsp0_data", 32'(rd0), 32'(m_hold[0]));
        chk("rsp1_data", 32'(rd1), 32'(m_hold[1]));
        @(posedge clk);
        m_rsp = 1'b0;
        if (m_idle && (e_r0 || e_r1)) begin
            m_idle = 1'b0; m_elapsed = 1; m_owner = e_r1; m_last = e_r1;
            m_we    = e_r1 ? we1 : we0;
            m_maddr = e_r1 ? a1 : a0;
            m_mdata = e_r1 ? d1 : d0;
            m_dur   = m_we ? 1 : 1 + RL;
            if (m_we) begin
                sh[m_maddr[7:0]] = m_mdata;
                m_rdata = 8'h0;
            end else begin
                m_rdata = sh[m_maddr[7:0]];
            end
        end else if (!m_idle) begin
            if (m_elapsed == m_dur) begin
                m_idle = 1'b1; m_rsp = 1'b1; m_hold[m_owner] = m_rdata;
            end else begin
                m_elapsed++;
            end
        end
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(m_idle && !m_rsp) && n < 20) begin step(); n++; end
        step();
        chk(name, 32'(n < 20), 32'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0; t3_v0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic rand_drive();
        if (m_hs0 || !v0) begin
            if ((m_hs0 && $urandom_range(1, 0) == 1) || (!m_hs0 && $urandom_range(99, 0) < 40)) begin
                v0 = 1'b1; we0 = 1'($urandom_range(1, 0)); a0 = 32'($urandom_range(15, 0)); d0 = 8'($urandom);
            end else begin
                v0 = 1'b0;
            end
        end else if ($urandom_range(99, 0) < 5) begin
            v0 = 1'b0;
        end else begin
            v0 = 1'b1;
        end
        if (m_hs1 || !v1) begin
            if ((m_hs1 && $urandom_range(1, 0) == 1) || (!m_hs1 && $urandom_range(99, 0) < 40)) begin
                v1 = 1'b1; we1 = 1'($urandom_range(1, 0)); a1 = 32'($urandom_range(15, 0)); d1 = 8'($urandom);
            end else begin
                v1 = 1'b0;
            end
        end else if ($urandom_range(99, 0) < 5) begin
            v1 = 1'b0;
        end else begin
            v1 = 1'b1;
        end
    endtask

    // in_f = {v0, we0, v1, we1}; exp_f = {ready0, ready1, mem_we, busy, rsp0_valid, rsp1_valid, grant_id}
    typedef struct {
        logic [3:0] in_f;
        logic [7:0] a0, d0, a1;
        logic [6:0] exp_f;
        logic [7:0] maddr, mdin, rd1;
    } vec_t;
    vec_t tbl [7];

    initial begin
        tbl = '{
            '{4'b1100, 8'h10, 8'hA5, 8'h00, 7'b1000000, 8'h00, 8'h00, 8'h00},
            '{4'b0000, 8'h00, 8'h00, 8'h00, 7'b0011000, 8'h10, 8'hA5, 8'h00},
            '{4'b0010, 8'h00, 8'h00, 8'h10, 7'b0100100, 8'h10, 8'hA5, 8'h00},
            '{4'b0000, 8'h00, 8'h00, 8'h00, 7'b0001001, 8'h10, 8'h77, 8'h00},
            '{4'b0000, 8'h00, 8'h00, 8'h00, 7'b0001001, 8'h10, 8'h77, 8'h00},
            '{4'b0000, 8'h00, 8'h00, 8'h00, 7'b0000011, 8'h10, 8'h77, 8'hA5},
            '{4'b0000, 8'h00, 8'h00, 8'h00, 7'b0000001, 8'h10, 8'h77, 8'hA5}
        };
        for (int i = 0; i < 256; i++) sh[i] = i[7:0] ^ 8'h5A;
        reset = 1'b1;
        v0 = 1'b0; we0 = 1'b0; a0 = 32'h0; d0 = 8'h0;
        v1 = 1'b0; we1 = 1'b0; a1 = 32'h0; d1 = 8'h0;
        t3_v0 = 1'b0; t3_we0 = 1'b0; t3_a0 = 32'h0; t3_d0 = 8'h0;
        t3_v1 = 1'b0; t3_we1 = 1'b0; t3_a1 = 32'h0; t3_d1 = 8'h0;
        t3_mdout = 8'hEE;
        model_reset();

        // READ_LATENCY=3 read on the second instance.
        do_reset();
        t3_v0 = 1'b1; t3_a0 = 32'h20;
        @(negedge clk);
        chk("rl3.ready0_t", 32'(t3_r0), 32'(1));
        chk("rl3.busy_t", 32'(t3_busy), 32'(0));
        @(posedge clk); #1;
        t3_v0 = 1'b0; t3_a0 = 32'h99;
        for (int c = 1; c <= 6; c++) begin
            t3_mdout = (c == 4) ? 8'h3C : 8'hEE;
            @(negedge clk);
            chk($sformatf("rl3.mem_addr_t%0d", c), t3_maddr, 32'h20);
            chk($sformatf("rl3.mem_we_t%0d", c), 32'(t3_mwe), 32'(0));
            chk($sformatf("rl3.busy_t%0d", c), 32'(t3_busy), 32'(c <= 4));
            chk($sformatf("rl3.rsp0_valid_t%0d", c), 32'(t3_rv0), 32'(c == 5));
            chk($sformatf("rl3.rsp1_valid_t%0d", c), 32'(t3_rv1), 32'(0));
            if (c >= 5) chk($sformatf("rl3.rsp0_data_t%0d", c), 32'(t3_rd0), 32'h3C);
            @(posedge clk); #1;
        end

        // Write 0xA5 to 0x10 from req0, then read it back from req1.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            v0 = tbl[i].in_f[3]; we0 = tbl[i].in_f[2]; v1 = tbl[i].in_f[1]; we1 = tbl[i].in_f[0];
            a0 = 32'(tbl[i].a0); d0 = tbl[i].d0; a1 = 32'(tbl[i].a1); d1 = 8'h77;
            @(negedge clk);
            chk($sformatf("tbl%0d.ready0", i), 32'(r0), 32'(tbl[i].exp_f[6]));
            chk($sformatf("tbl%0d.ready1", i), 32'(r1), 32'(tbl[i].exp_f[5]));
            chk($sformatf("tbl%0d.mem_we", i), 32'(mwe), 32'(tbl[i].exp_f[4]));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].exp_f[3]));
            chk($sformatf("tbl%0d.rsp0_valid", i), 32'(rv0), 32'(tbl[i].exp_f[2]));
            chk($sformatf("tbl%0d.rsp1_valid", i), 32'(rv1), 32'(tbl[i].exp_f[1]));
            chk($sformatf("tbl%0d.grant_id", i), 32'(gid), 32'(tbl[i].exp_f[0]));
            chk($sformatf("tbl%0d.mem_addr", i), maddr, 32'(tbl[i].maddr));
            chk($sformatf("tbl%0d.mem_dataIn", i), 32'(mdin), 32'(tbl[i].mdin));
            chk($sformatf("tbl%0d.rsp1_data", i), 32'(rd1), 32'(tbl[i].rd1));
            chk($sformatf("tbl%0d.rsp0_data", i), 32'(rd0), 32'h0);
            @(posedge clk); #1;
        end
        sh[8'h10] = 8'hA5;

        // Reset in the access cycle of a write abandons it.
        do_reset();
        v0 = 1'b1; we0 = 1'b1; a0 = 32'h12; d0 = 8'hC3;
        step();
        v0 = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rst.mem_we_t1", 32'(mwe), 32'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        repeat (3) step();
        v0 = 1'b1; v1 = 1'b1; we0 = 1'b0; we1 = 1'b0; a0 = 32'h21; a1 = 32'h22;
        step();
        chk("rst.first_tie_req0", 32'(act_r0), 32'(1));
        v0 = 1'b0; v1 = 1'b0;
        drain("rst.drain");

        // Fairness: both continuously valid with reads.
        do_reset();
        gq.delete();
        v0 = 1'b1; v1 = 1'b1; we0 = 1'b0; we1 = 1'b0; a0 = 32'h30; a1 = 32'h40; d0 = 8'h01; d1 = 8'h02;
        for (int n = 0; n < 60 && gq.size() < 6; n++) step();
        v0 = 1'b0; v1 = 1'b0;
        chk("fair.grant_count", 32'(gq.size() >= 6), 32'(1));
        for (int k = 0; k < 6 && k < gq.size(); k++)
            chk($sformatf("fair.grant%0d", k), 32'(gq[k]), 32'(k % 2));
        drain("fair.drain");

        // req0 drops valid while req1 holds: req1 is served, req0 gets nothing.
        v1 = 1'b1; we1 = 1'b1; a1 = 32'h05; d1 = 8'h66;
        step();
        v0 = 1'b1; we0 = 1'b0; a0 = 32'h50; v1 = 1'b1; we1 = 1'b0; a1 = 32'h06;
        step();
        v0 = 1'b0;
        step();
        chk("drop.ready1", 32'(act_r1), 32'(1));
        chk("drop.ready0", 32'(act_r0), 32'(0));
        v1 = 1'b0;
        drain("drop.drain");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step();
            rand_drive();
        end
        v0 = 1'b0; v1 = 1'b0;
        drain("rand.drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
